// File: rtl/prog_rom_arbiter.sv
// Shares one combinational program ROM between the CPU fetch port and the debug
// readback port: single grant per cycle, registered read data one cycle later.
module prog_rom_arbiter #(
  parameter int AW           = 10,
  parameter int DW           = 16,
  parameter int DBG_MAX_WAIT = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          f_req,
  input  logic [AW-1:0] f_addr,
  output logic          f_gnt,
  output logic          f_rvalid,
  output logic [DW-1:0] f_rdata,
  input  logic          d_req,
  input  logic [AW-1:0] d_addr,
  input  logic          d_halt,
  output logic          d_gnt,
  output logic          d_rvalid,
  output logic [DW-1:0] d_rdata,
  output logic [AW-1:0] rom_addr,
  input  logic [DW-1:0] rom_dout
);

  localparam int WCW = (DBG_MAX_WAIT > 0) ? $clog2(DBG_MAX_WAIT + 1) : 1;
  localparam logic [WCW-1:0] WAIT_MAX = WCW'(DBG_MAX_WAIT);

  logic          f_elig, d_elig;
  logic [WCW-1:0] wait_cnt_q, wait_cnt_d;
  logic [AW-1:0] last_addr_q, last_addr_d;
  logic          f_rvalid_q, d_rvalid_q;
  logic [DW-1:0] f_rdata_q, f_rdata_d, d_rdata_q, d_rdata_d;

  assign f_elig = f_req && !d_halt;
  assign d_elig = d_req;

  // Debug wins a contest only once it has lost DBG_MAX_WAIT of them in a row.
  assign d_gnt = d_elig && (!f_elig || (wait_cnt_q == WAIT_MAX));
  assign f_gnt = f_elig && !d_gnt;

  always_comb begin
    rom_addr    = last_addr_q;
    last_addr_d = last_addr_q;
    f_rdata_d   = f_rdata_q;
    d_rdata_d   = d_rdata_q;
    wait_cnt_d  = wait_cnt_q;
    if (d_gnt) begin
      rom_addr    = d_addr;
      last_addr_d = d_addr;
      d_rdata_d   = rom_dout;
    end else if (f_gnt) begin
      rom_addr    = f_addr;
      last_addr_d = f_addr;
      f_rdata_d   = rom_dout;
    end
    if (d_gnt) begin
      wait_cnt_d = '0;
    end else if (d_req && (wait_cnt_q != WAIT_MAX)) begin
      wait_cnt_d = wait_cnt_q + WCW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt_q  <= '0;
      last_addr_q <= '0;
      f_rvalid_q  <= 1'b0;
      d_rvalid_q  <= 1'b0;
      f_rdata_q   <= '0;
      d_rdata_q   <= '0;
    end else begin
      wait_cnt_q  <= wait_cnt_d;
      last_addr_q <= last_addr_d;
      f_rvalid_q  <= f_gnt;
      d_rvalid_q  <= d_gnt;
      f_rdata_q   <= f_rdata_d;
      d_rdata_q   <= d_rdata_d;
    end
  end

  assign f_rvalid = f_rvalid_q;
  assign d_rvalid = d_rvalid_q;
  assign f_rdata  = f_rdata_q;
  assign d_rdata  = d_rdata_q;

endmodule

// File: tb/tb_prog_rom_arbiter.sv
// Bench for prog_rom_arbiter: directed vector table, reset/halt sequences and
// constrained-random traffic against a cycle model of the arbitration rules.
module tb_prog_rom_arbiter;

  localparam int AW   = 10;
  localparam int DW   = 16;
  localparam int MAXW = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          f_req, d_req, d_halt;
  logic [AW-1:0] f_addr, d_addr;
  logic          f_gnt, d_gnt, f_rvalid, d_rvalid;
  logic [DW-1:0] f_rdata, d_rdata, rom_dout;
  logic [AW-1:0] rom_addr;

  int checks = 0;
  int failures = 0;

  // Model state
  int            m_cnt;
  logic [AW-1:0] m_last;
  logic          m_frv, m_drv;
  logic [DW-1:0] m_frd, m_drd;

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] rom_fn(input logic [AW-1:0] a);
    if (a == 10'h3FF) return '0;
    return 16'({6'(a) ^ 6'h2B, a} ^ 16'hA5C3);
  endfunction

  assign rom_dout = rom_fn(rom_addr);

  prog_rom_arbiter #(.AW(AW), .DW(DW), .DBG_MAX_WAIT(MAXW)) dut (
    .clk(clk), .rst_n(rst_n),
    .f_req(f_req), .f_addr(f_addr), .f_gnt(f_gnt), .f_rvalid(f_rvalid), .f_rdata(f_rdata),
    .d_req(d_req), .d_addr(d_addr), .d_halt(d_halt), .d_gnt(d_gnt), .d_rvalid(d_rvalid),
    .d_rdata(d_rdata), .rom_addr(rom_addr), .rom_dout(rom_dout)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_cnt = 0; m_last = '0; m_frv = 0; m_drv = 0; m_frd = '0; m_drd = '0;
  endtask

  // Entered 1 time unit after a rising edge; returns 1 unit after the next one.
  task automatic step(input logic fr, input logic [AW-1:0] fa, input logic dr,
                      input logic [AW-1:0] da, input logic hl,
                      output logic fwin, output logic dwin);
    logic fe;
    logic [AW-1:0] ea;
    f_req = fr; f_addr = fa; d_req = dr; d_addr = da; d_halt = hl;
    fe = fr && !hl;
    if (fe && dr) dwin = (m_cnt >= MAXW);
    else          dwin = dr;
    fwin = fe && !dwin;
    ea = dwin ? da : (fwin ? fa : m_last);
    #3;
    chk("f_gnt", 32'(f_gnt), 32'(fwin));
    chk("d_gnt", 32'(d_gnt), 32'(dwin));
    chk("rom_addr", 32'(rom_addr), 32'(ea));
    chk("f_rvalid", 32'(f_rvalid), 32'(m_frv));
    chk("d_rvalid", 32'(d_rvalid), 32'(m_drv));
    chk("f_rdata", 32'(f_rdata), 32'(m_frd));
    chk("d_rdata", 32'(d_rdata), 32'(m_drd));
    @(posedge clk);
    m_frv = fwin;
    m_drv = dwin;
    if (fwin) m_frd = rom_fn(fa);
    if (dwin) m_drd = rom_fn(da);
    if (fwin || dwin) m_last = ea;
    if (dwin)    m_cnt = 0;
    else if (dr) m_cnt = (m_cnt + 1 > MAXW) ? MAXW : m_cnt + 1;
    #1;
  endtask

  typedef struct {
    logic          fr;
    logic [AW-1:0] fa;
    logic          dr;
    logic [AW-1:0] da;
    logic          hl;
    logic          exp_fg;
    logic          exp_dg;
  } vec_t;

  vec_t vecs[$];

  initial begin
    logic fg, dg;
    logic cfr, cdr;
    logic [AW-1:0] cfa, cda;

    rst_n = 1'b0; f_req = 0; d_req = 0; d_halt = 0; f_addr = '0; d_addr = '0;
    model_reset();
    #12;
    chk("rst_f_rvalid", 32'(f_rvalid), 32'd0);
    chk("rst_d_rvalid", 32'(d_rvalid), 32'd0);
    chk("rst_f_rdata", 32'(f_rdata), 32'd0);
    chk("rst_d_rdata", 32'(d_rdata), 32'd0);
    chk("rst_rom_addr", 32'(rom_addr), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Fetch-only burst 0x000..0x007
    for (int i = 0; i < 8; i++) vecs.push_back('{1, 10'(i), 0, 10'h0, 0, 1, 0});
    // Contest: four fetch wins then one debug win, twice
    for (int i = 0; i < 10; i++)
      vecs.push_back('{1, 10'h010, 1, 10'h200, 0, (i % 5 != 4), (i % 5 == 4)});
    // Halt: debug granted at once, fetch held off until halt drops
    vecs.push_back('{1, 10'h020, 1, 10'h100, 1, 0, 1});
    vecs.push_back('{1, 10'h020, 0, 10'h000, 1, 0, 0});
    vecs.push_back('{1, 10'h020, 0, 10'h000, 1, 0, 0});
    vecs.push_back('{1, 10'h020, 0, 10'h000, 0, 1, 0});
    // Idle hold after a debug grant
    vecs.push_back('{0, 10'h000, 1, 10'h104, 0, 0, 1});
    for (int i = 0; i < 3; i++) vecs.push_back('{0, 10'h3C3, 0, 10'h2AA, 0, 0, 0});
    // Top address
    vecs.push_back('{1, 10'h3FF, 0, 10'h000, 0, 1, 0});
    vecs.push_back('{0, 10'h000, 0, 10'h000, 0, 0, 0});

    foreach (vecs[i]) begin
      step(vecs[i].fr, vecs[i].fa, vecs[i].dr, vecs[i].da, vecs[i].hl, fg, dg);
      chk("tbl_f_gnt", 32'(fg), 32'(vecs[i].exp_fg));
      chk("tbl_d_gnt", 32'(dg), 32'(vecs[i].exp_dg));
    end
    // rom_addr after idle stays at last grant (0x3FF) and f_rdata is the top word
    chk("top_word", 32'(f_rdata), 32'(16'h0000));
    chk("idle_rom_addr", 32'(rom_addr), 32'(10'h3FF));

    // Reset in the cycle after a fetch grant
    step(1, 10'h055, 0, 10'h0, 0, fg, dg);
    f_req = 0; d_req = 0;
    #1;
    chk("pre_rst_f_rvalid", 32'(f_rvalid), 32'd1);
    chk("pre_rst_f_rdata", 32'(f_rdata), 32'(rom_fn(10'h055)));
    rst_n = 1'b0;
    #1;
    chk("mid_rst_f_rvalid", 32'(f_rvalid), 32'd0);
    chk("mid_rst_f_rdata", 32'(f_rdata), 32'd0);
    chk("mid_rst_rom_addr", 32'(rom_addr), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    model_reset();
    step(0, 10'h0, 0, 10'h0, 0, fg, dg);
    step(0, 10'h0, 0, 10'h0, 0, fg, dg);

    // Random traffic obeying the request hold rule
    cfr = 0; cdr = 0; cfa = '0; cda = '0; fg = 0; dg = 0;
    for (int i = 0; i < 400; i++) begin
      if (!(cfr && !fg)) begin
        cfr = ($urandom % 4) != 0;
        cfa = 10'($urandom);
      end
      if (!(cdr && !dg)) begin
        cdr = ($urandom % 3) == 0;
        cda = 10'($urandom);
      end
      step(cfr, cfa, cdr, cda, ($urandom % 8) == 0, fg, dg);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
